// File: rtl/d_sram_axi_bridge.sv
// d_sram_axi_bridge: converts the data cache's sram-like request/response
// handshake into single-beat AXI3 read or write transactions, with one
// transaction outstanding at a time.
module d_sram_axi_bridge #(
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input  logic        clk,
   input  logic        rst,
   // cache side
   input  logic        cache_data_req,
   input  logic        cache_data_wr,
   input  logic [1:0]  cache_data_size,
   input  logic [31:0] cache_data_addr,
   input  logic [31:0] cache_data_wdata,
   output logic [31:0] cache_data_rdata,
   output logic        cache_data_addr_ok,
   output logic        cache_data_data_ok,
   output logic        bus_err,
   // AXI ids
   output logic [3:0]  arid,
   output logic [3:0]  awid,
   output logic [3:0]  wid,
   // read address channel
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   // read data channel
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   // write address channel
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   // write data channel
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // write response channel
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RADDR,
      S_RDATA,
      S_WREQ,
      S_WRESP
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [3:0]  strb_calc;
   logic        aw_hs;
   logic        w_hs;

   // Byte-lane strobes for the incoming request, derived from size and low address bits.
   always_comb begin
      strb_calc = 4'b1111;
      case (cache_data_size)
         2'd0:    strb_calc = 4'b0001 << cache_data_addr[1:0];
         2'd1:    strb_calc = cache_data_addr[1] ? 4'b1100 : 4'b0011;
         default: strb_calc = 4'b1111;
      endcase
   end

   // Next-state and output decode; only latched request fields ever reach the bus.
   always_comb begin
      state_d            = state_q;
      addr_d             = addr_q;
      size_d             = size_q;
      wdata_d            = wdata_q;
      wstrb_d            = wstrb_q;
      rdata_d            = rdata_q;
      aw_done_d          = aw_done_q;
      w_done_d           = w_done_q;
      aw_hs              = 1'b0;
      w_hs               = 1'b0;
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      cache_data_rdata   = rdata_q;
      bus_err            = 1'b0;
      arvalid            = 1'b0;
      rready             = 1'b0;
      awvalid            = 1'b0;
      wvalid             = 1'b0;
      bready             = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Gated by rst so addr_ok stays low while reset is held.
            cache_data_addr_ok = cache_data_req & rst;
            if (cache_data_req) begin
               addr_d    = cache_data_addr;
               size_d    = cache_data_size;
               wdata_d   = cache_data_wdata;
               wstrb_d   = strb_calc;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cache_data_wr ? S_WREQ : S_RADDR;
            end
         end
         S_RADDR: begin
            arvalid = 1'b1;
            if (arready) begin
               state_d = S_RDATA;
            end
         end
         S_RDATA: begin
            rready = 1'b1;
            if (rvalid) begin
               // Read data passes straight through in the completion cycle.
               cache_data_data_ok = 1'b1;
               cache_data_rdata   = rdata;
               rdata_d            = rdata;
               bus_err            = (rresp != 2'b00);
               state_d            = S_IDLE;
            end
         end
         S_WREQ: begin
            awvalid   = ~aw_done_q;
            wvalid    = ~w_done_q;
            aw_hs     = awvalid & awready;
            w_hs      = wvalid & wready;
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            // Covers both handshakes landing in the same cycle.
            if (aw_done_d && w_done_d) begin
               state_d = S_WRESP;
            end
         end
         S_WRESP: begin
            bready = 1'b1;
            if (bvalid) begin
               cache_data_data_ok = 1'b1;
               bus_err            = (bresp != 2'b00);
               state_d            = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched request registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= 32'd0;
         size_q    <= 2'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         rdata_q   <= 32'd0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign arid   = AXI_ID;
   assign awid   = AXI_ID;
   assign wid    = AXI_ID;
   assign araddr = addr_q;
   assign arsize = {1'b0, size_q};
   assign awaddr = addr_q;
   assign awsize = {1'b0, size_q};
   assign wdata  = wdata_q;
   assign wstrb  = wstrb_q;
   assign wlast  = 1'b1;

endmodule
